alu_issue_ctrl: RTL and testbench

//  Initiator side of the 16-bit ALU interface: accepts one operation request over valid/ready,

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_check.sv | 19 +
 rtl/alu_issue_ctrl.sv | 107 ++++++++++
 tb/tb_alu_issue_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, op codes and issue-controller state encoding.
package alu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NONE = 4'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd2;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd3;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OP_W-1:0] OP_AND  = 4'd8;
  localparam logic [OP_W-1:0] OP_OR   = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } issue_state_e;

  // True when the op code names one of the implemented ALU functions.
  function automatic logic op_in_range(logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

endpackage

// File: rtl/alu_op_check.sv
// Combinational request screen: flags unknown op codes and divide-by-zero.
module alu_op_check #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
  input  logic [alu_pkg::OP_W-1:0] op,
  input  logic [DATA_W-1:0]        b,
  output logic                     illegal
);
  import alu_pkg::*;

  logic div_by_zero;

  // Illegal when the op is out of range or a division has a zero divisor.
  always_comb begin
    div_by_zero = (op == OP_DIV) && (b == '0);
    illegal     = !op_in_range(op) || div_by_zero;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational ALU: accepts one request, drives the ALU for a
// single cycle, captures result/flags and returns them on a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [alu_pkg::OP_W-1:0] req_op,
  input  logic [DATA_W-1:0]        req_a,
  input  logic [DATA_W-1:0]        req_b,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [alu_pkg::OP_W-1:0] alu_control,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic                     alu_z,
  input  logic                     alu_g,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_result,
  output logic                     rsp_z,
  output logic                     rsp_g,
  output logic                     rsp_err,
  output logic [CNT_W-1:0]         op_count
);
  import alu_pkg::*;

  issue_state_e state_q;
  logic         req_illegal;

  alu_op_check #(
    .DATA_W (DATA_W)
  ) u_op_check (
    .op      (req_op),
    .b       (req_b),
    .illegal (req_illegal)
  );

  // Ready only in IDLE; gated by rst so no request looks accepted while reset is held.
  always_comb begin
    req_ready = (state_q == StIdle) && !rst;
  end

  // Single FSM: state, ALU drive registers (double as the request latch), response
  // registers and the saturating issue counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_z       <= 1'b0;
      rsp_g       <= 1'b0;
      rsp_err     <= 1'b0;
      op_count    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            if (req_illegal) begin
              // Rejected requests skip the ALU entirely and answer with an error.
              state_q    <= StResp;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_z      <= 1'b0;
              rsp_g      <= 1'b0;
              rsp_err    <= 1'b1;
            end else begin
              state_q     <= StIssue;
              alu_a       <= req_a;
              alu_b       <= req_b;
              alu_control <= req_op;
            end
          end
        end
        StIssue: begin
          state_q     <= StResp;
          rsp_valid   <= 1'b1;
          rsp_result  <= alu_result;
          rsp_z       <= alu_z;
          rsp_g       <= alu_g;
          rsp_err     <= 1'b0;
          alu_a       <= '0;
          alu_b       <= '0;
          alu_control <= '0;
          if (op_count != {CNT_W{1'b1}}) begin
            op_count <= op_count + CNT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q   <= StIdle;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed cases then random ops against a
// behavioural ALU model; also provides the combinational ALU the controller drives.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_control;
  logic [15:0] alu_result;
  logic        alu_z;
  logic        alu_g;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_z;
  logic        rsp_g;
  logic        rsp_err;
  logic [15:0] op_count;

  int errors = 0;
  int checks = 0;
  int unsigned exp_count = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_W (16),
    .CNT_W  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_z       (alu_z),
    .alu_g       (alu_g),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_z       (rsp_z),
    .rsp_g       (rsp_g),
    .rsp_err     (rsp_err),
    .op_count    (op_count)
  );

  // Behavioural ALU: returns {g, z, result} from plain integer arithmetic.
  function automatic logic [17:0] alu_model(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    int unsigned ua;
    int unsigned ub;
    int unsigned w;
    logic [15:0] r;
    ua = a;
    ub = b;
    case (op)
      4'd1: w = ua + ub;
      4'd2: w = ua - ub;
      4'd3: w = ua * ub;
      4'd4: w = (ub != 0) ? ua / ub : 0;
      4'd5: w = ~ua;
      4'd6: w = (ub >= 16) ? 0 : (ua << ub);
      4'd7: w = (ub >= 16) ? 0 : (ua >> ub);
      4'd8: w = ua & ub;
      4'd9: w = ua | ub;
      default: w = 0;
    endcase
    r = w[15:0];
    return {(ua < ub), (r == 16'd0), r};
  endfunction

  // ALU responder seen by the controller.
  always_comb begin
    {alu_g, alu_z, alu_result} = alu_model(alu_control, alu_a, alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from IDLE back to IDLE; hold = cycles of rsp_ready low in RESP.
  // Entered and left at posedge+1.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input int hold);
    logic        bad;
    logic [17:0] m;
    logic [15:0] e_res;
    logic        e_z;
    logic        e_g;
    bad = (op == 4'd0) || (op > 4'd9) || (op == 4'd4 && b == 16'd0);
    m   = alu_model(op, a, b);
    if (bad) begin
      e_res = 16'd0;
      e_z   = 1'b0;
      e_g   = 1'b0;
    end else begin
      e_res = m[15:0];
      e_z   = m[16];
      e_g   = m[17];
    end
    check({tag, " req_ready_idle"}, req_ready, 1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = $urandom();
    req_a     = $urandom();
    req_b     = $urandom();
    check({tag, " req_ready_busy"}, req_ready, 0);
    if (bad) begin
      check({tag, " alu_ctl_idle"}, alu_control, 0);
      check({tag, " alu_a_idle"}, alu_a, 0);
    end else begin
      check({tag, " rsp_valid_early"}, rsp_valid, 0);
      check({tag, " alu_ctl"}, alu_control, op);
      check({tag, " alu_a"}, alu_a, a);
      check({tag, " alu_b"}, alu_b, b);
      if (exp_count != 32'hFFFF) exp_count++;
      @(posedge clk);
      #1;
      check({tag, " alu_ctl_after"}, alu_control, 0);
    end
    check({tag, " rsp_valid"}, rsp_valid, 1);
    check({tag, " rsp_result"}, rsp_result, e_res);
    check({tag, " rsp_flags"}, {rsp_err, rsp_g, rsp_z}, {bad, e_g, e_z});
    check({tag, " op_count"}, op_count, exp_count);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold_valid"}, rsp_valid, 1);
      check({tag, " hold_result"}, rsp_result, e_res);
      check({tag, " hold_flags"}, {rsp_err, rsp_g, rsp_z}, {bad, e_g, e_z});
      check({tag, " hold_req_ready"}, req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " rsp_done"}, rsp_valid, 0);
    check({tag, " back_idle"}, req_ready, 1);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 4'd0;
    req_a     = 16'd0;
    req_b     = 16'd0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", req_ready, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_result", rsp_result, 0);
    check("reset flags", {rsp_err, rsp_g, rsp_z}, 0);
    check("reset alu", {alu_a, alu_b, alu_control}, 0);
    check("reset op_count", op_count, 0);
    rst = 1'b0;
    #1;
    check("post_reset req_ready", req_ready, 1);

    // Directed cases with hand-derived expectations.
    do_op("add", 4'd1, 16'd300, 16'd45, 0);
    check("add value", rsp_result, 16'd345);
    do_op("sub_zero", 4'd2, 16'd7, 16'd7, 0);
    do_op("sub_neg", 4'd2, 16'd3, 16'd9, 0);
    check("sub_neg value", rsp_result, 16'hFFFA);
    check("sub_neg g", rsp_g, 1);
    do_op("div0", 4'd4, 16'd100, 16'd0, 0);
    check("div0 count", op_count, 3);
    do_op("op12", 4'd12, 16'd1, 16'd1, 0);
    do_op("op0", 4'd0, 16'd1, 16'd1, 0);
    check("illegal count", op_count, 3);
    do_op("mul_bp", 4'd3, 16'd200, 16'd400, 5);
    check("mul_bp value", rsp_result, 16'h3880);
    do_op("shl_big", 4'd6, 16'h1234, 16'd16, 0);
    do_op("shr", 4'd7, 16'h8000, 16'd15, 1);

    // Reset asserted during the ISSUE cycle drops the op.
    req_valid = 1'b1;
    req_op    = 4'd1;
    req_a     = 16'd5;
    req_b     = 16'd6;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("midrst in_issue", alu_control, 4'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst rsp_valid", rsp_valid, 0);
    check("midrst op_count", op_count, 0);
    check("midrst alu_ctl", alu_control, 0);
    check("midrst req_ready_in_rst", req_ready, 0);
    rst = 1'b0;
    exp_count = 0;
    #1;
    check("midrst req_ready", req_ready, 1);
    @(posedge clk);
    #1;
    check("midrst no_rsp", rsp_valid, 0);
    do_op("or", 4'd9, 16'h00F0, 16'h0F00, 0);
    check("or value", rsp_result, 16'h0FF0);

    // Random ops against the model.
    for (int n = 0; n < 60; n++) begin
      r_op = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(0, 15));
      r_a  = 16'($urandom());
      case ($urandom_range(0, 4))
        0:       r_b = 16'd0;
        1:       r_b = 16'($urandom_range(0, 20));
        2:       r_b = r_a;
        default: r_b = 16'($urandom());
      endcase
      do_op("rand", r_op, r_a, r_b, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
